// File: rtl/ans_freq_table.sv
// Symbol-model stage ahead of the ANS encoder: loads a per-symbol frequency table, builds cumulative
// counts during load, then maps raw symbols to (count, cumulative) beats. Optional: ANS_FREQ_ZERO_CHECK_EN.
module ans_freq_table #(
  parameter int SYM_WIDTH   = 4,
  parameter int CNT_WIDTH   = 4,
  parameter int STATE_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic [CNT_WIDTH-1:0]           cfg_count,
  input  logic                           cfg_last,
  input  logic                           cfg_vld,
  output logic                           cfg_rdy,
  input  logic                           reload,
  output logic                           table_ready,
  input  logic [SYM_WIDTH-1:0]           sym_in,
  input  logic                           sym_vld,
  output logic                           sym_rdy,
  output logic [CNT_WIDTH-1:0]           s_count,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  output logic [STATE_WIDTH-1:0]         total_count,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic                           sym_err
);
  localparam int NSYM  = 1 << SYM_WIDTH;
  localparam int CUM_W = SYM_WIDTH + CNT_WIDTH;

  typedef enum logic [1:0] {LOAD, READY, DRAIN} state_t;

  state_t                         state;
  logic [NSYM-1:0][CNT_WIDTH-1:0] cnt_tab;
  logic [NSYM-1:0][CUM_W-1:0]     cum_tab;
  logic [SYM_WIDTH-1:0]           idx;
  logic [CUM_W-1:0]               acc, acc_nxt;
  logic                           cfg_fire, sym_fire, out_fire, last_beat, drop_beat, drain_done;

  assign cfg_rdy    = ena && (state == LOAD);
  assign sym_rdy    = ena && (state == READY) && !reload && (!out_vld || out_rdy);
  assign cfg_fire   = cfg_vld && cfg_rdy && !reload;
  assign sym_fire   = sym_vld && sym_rdy;
  assign out_fire   = out_vld && out_rdy;
  assign acc_nxt    = acc + CUM_W'(cfg_count);
  assign last_beat  = cfg_last || (idx == SYM_WIDTH'(NSYM - 1));
  assign drain_done = (state == DRAIN) && !out_vld;

`ifdef ANS_FREQ_ZERO_CHECK_EN
  assign drop_beat = (cnt_tab[sym_in] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sym_err <= 1'b0;
    else if (ena) begin
      if (drain_done || (state == LOAD && reload))
        sym_err <= 1'b0;
      else if (sym_fire && drop_beat)
        sym_err <= 1'b1;
    end
  end
`else
  assign drop_beat = 1'b0;
  assign sym_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      idx          <= '0;
      acc          <= '0;
      cnt_tab      <= '0;
      cum_tab      <= '0;
      out_vld      <= 1'b0;
      s_count      <= '0;
      s_cumulative <= '0;
      total_count  <= '0;
      table_ready  <= 1'b0;
    end else if (ena) begin
      // A new accept reloads the output register even while the old beat leaves this cycle.
      if (sym_fire && !drop_beat) begin
        out_vld      <= 1'b1;
        s_count      <= cnt_tab[sym_in];
        s_cumulative <= cum_tab[sym_in];
      end else if (out_fire) begin
        out_vld <= 1'b0;
      end

      case (state)
        LOAD: begin
          if (reload) begin
            idx         <= '0;
            acc         <= '0;
            cnt_tab     <= '0;
            cum_tab     <= '0;
            total_count <= '0;
          end else if (cfg_fire) begin
            cnt_tab[idx] <= cfg_count;
            cum_tab[idx] <= acc;
            acc          <= acc_nxt;
            if (last_beat) begin
              // Unloaded tail symbols have count 0 but still sit above every loaded symbol.
              for (int i = 0; i < NSYM; i++)
                if (i > int'(idx)) cum_tab[i] <= acc_nxt;
              total_count <= STATE_WIDTH'(acc_nxt);
              table_ready <= 1'b1;
              state       <= READY;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        READY: if (reload) state <= DRAIN;
        DRAIN: begin
          if (!out_vld) begin
            idx         <= '0;
            acc         <= '0;
            cnt_tab     <= '0;
            cum_tab     <= '0;
            total_count <= '0;
            table_ready <= 1'b0;
            state       <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ans_freq_table.sv
// Directed bench for ans_freq_table: scoreboard of expected (count, cumulative) beats checked on handshake.
module tb_ans_freq_table;
  logic       clk = 1'b0;
  logic       rst_n, ena, cfg_last, cfg_vld, cfg_rdy, reload, table_ready;
  logic [3:0] cfg_count, sym_in, s_count;
  logic       sym_vld, sym_rdy, out_vld, out_rdy, sym_err;
  logic [7:0] s_cumulative, total_count;

  typedef struct packed {
    logic [3:0] c;
    logic [7:0] m;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
`ifdef ANS_FREQ_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  ans_freq_table #(.SYM_WIDTH(4), .CNT_WIDTH(4), .STATE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_count(cfg_count), .cfg_last(cfg_last), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .reload(reload), .table_ready(table_ready),
    .sym_in(sym_in), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .s_count(s_count), .s_cumulative(s_cumulative), .total_count(total_count),
    .out_vld(out_vld), .out_rdy(out_rdy), .sym_err(sym_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check any output handshake at the negedge, return 1 time unit after the posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (out_vld && out_rdy && ena) begin
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("beat_count", 32'(s_count), 32'(e.c));
        chk("beat_cum", 32'(s_cumulative), 32'(e.m));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] c, input logic last);
    cfg_count = c;
    cfg_last  = last;
    cfg_vld   = 1'b1;
    cyc();
    cfg_vld   = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] ec, input logic [7:0] em, input bit beat);
    int n;
    if (beat) sb.push_back('{c: ec, m: em});
    sym_in  = s;
    sym_vld = 1'b1;
    #1;
    for (n = 0; n < 20 && !sym_rdy; n++) cyc();
    chk("sym_rdy_wait", 32'(sym_rdy), 32'd1);
    cyc();
    sym_vld = 1'b0;
  endtask

  task automatic wait_cfg_rdy();
    int n;
    for (n = 0; n < 10 && !cfg_rdy; n++) cyc();
    chk("cfg_rdy_wait", 32'(cfg_rdy), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_count = '0; cfg_last = 1'b0; cfg_vld = 1'b0;
    reload = 1'b0; sym_in = '0; sym_vld = 1'b0; out_rdy = 1'b1;
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_total", 32'(total_count), 32'd0);
    chk("rst_table_ready", 32'(table_ready), 32'd0);
    chk("rst_sym_err", 32'(sym_err), 32'd0);
    chk("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
    chk("rst_sym_rdy", 32'(sym_rdy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table 3,1 ended by cfg_last
    cfg(4'd3, 1'b0);
    chk("t1_not_ready_mid", 32'(table_ready), 32'd0);
    cfg(4'd1, 1'b1);
    chk("t1_table_ready", 32'(table_ready), 32'd1);
    chk("t1_total", 32'(total_count), 32'd4);
    chk("t1_cfg_rdy_low", 32'(cfg_rdy), 32'd0);
    send(4'd1, 4'd1, 8'd3, 1'b1);
    chk("t1_out_vld", 32'(out_vld), 32'd1);
    chk("t1_s_count", 32'(s_count), 32'd1);
    chk("t1_s_cum", 32'(s_cumulative), 32'd3);
    cyc();
    chk("t1_out_vld_clr", 32'(out_vld), 32'd0);

    // Stream 0,1,0 with a two-cycle stall on the second beat
    out_rdy = 1'b1; sym_vld = 1'b1;
    sym_in = 4'd0; sb.push_back('{c: 4'd3, m: 8'd0}); cyc();
    sym_in = 4'd1; sb.push_back('{c: 4'd1, m: 8'd3}); cyc();
    out_rdy = 1'b0; sym_in = 4'd0;
    #1;
    chk("t3_stall_rdy", 32'(sym_rdy), 32'd0);
    chk("t3_stall_vld", 32'(out_vld), 32'd1);
    chk("t3_stall_cnt", 32'(s_count), 32'd1);
    cyc();
    chk("t3_hold_cnt", 32'(s_count), 32'd1);
    chk("t3_hold_cum", 32'(s_cumulative), 32'd3);
    chk("t3_hold_rdy", 32'(sym_rdy), 32'd0);
    cyc();
    out_rdy = 1'b1; sb.push_back('{c: 4'd3, m: 8'd0});
    #1;
    chk("t3_resume_rdy", 32'(sym_rdy), 32'd1);
    cyc();
    sym_vld = 1'b0;
    cyc();
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Zero-count symbol beyond the loaded entries
    send(4'd5, 4'd0, 8'd4, !ZCHK);
    if (ZCHK) begin
      chk("t4_no_beat", 32'(out_vld), 32'd0);
      chk("t4_err", 32'(sym_err), 32'd1);
    end else begin
      chk("t4_beat", 32'(out_vld), 32'd1);
      chk("t4_cum", 32'(s_cumulative), 32'd4);
      chk("t4_err", 32'(sym_err), 32'd0);
    end
    cyc();

    // Reload while a beat is stalled
    out_rdy = 1'b0;
    send(4'd0, 4'd3, 8'd0, 1'b1);
    sym_vld = 1'b1; sym_in = 4'd1; reload = 1'b1;
    #1;
    chk("t5_rdy_reload", 32'(sym_rdy), 32'd0);
    cyc();
    reload = 1'b0;
    #1;
    chk("t5_drain_vld", 32'(out_vld), 32'd1);
    chk("t5_drain_cnt", 32'(s_count), 32'd3);
    cyc(); cyc();
    out_rdy = 1'b1;
    #1;
    chk("t5_drain_rdy", 32'(sym_rdy), 32'd0);
    cyc();
    sym_vld = 1'b0;
    wait_cfg_rdy();
    chk("t5_table_ready", 32'(table_ready), 32'd0);
    chk("t5_total", 32'(total_count), 32'd0);
    chk("t5_sym_err", 32'(sym_err), 32'd0);
    cfg(4'd2, 1'b0);
    cfg(4'd2, 1'b1);
    chk("t5_total_new", 32'(total_count), 32'd4);
    send(4'd1, 4'd2, 8'd2, 1'b1);
    cyc();

    // Reload beats a simultaneous symbol; then a full 16-entry load
    sym_vld = 1'b1; sym_in = 4'd3; reload = 1'b1;
    #1;
    chk("t2_reload_wins", 32'(sym_rdy), 32'd0);
    cyc();
    reload = 1'b0; sym_vld = 1'b0;
    wait_cfg_rdy();
    for (int i = 0; i < 15; i++) cfg(4'd15, 1'b0);
    chk("t2_not_ready_15", 32'(table_ready), 32'd0);
    cfg(4'd15, 1'b0);
    chk("t2_table_ready", 32'(table_ready), 32'd1);
    chk("t2_total", 32'(total_count), 32'd240);
    send(4'd15, 4'd15, 8'd225, 1'b1);
    send(4'd0, 4'd15, 8'd0, 1'b1);
    cyc();

    // ena low freezes state and deasserts handshakes
    ena = 1'b0; reload = 1'b1; sym_vld = 1'b1;
    #1;
    chk("ena_sym_rdy", 32'(sym_rdy), 32'd0);
    cyc();
    chk("ena_hold_ready", 32'(table_ready), 32'd1);
    ena = 1'b1; reload = 1'b0; sym_vld = 1'b0;
    #1;
    chk("ena_resume_rdy", 32'(sym_rdy), 32'd1);

    // Reset in the middle of a load
    reload = 1'b1; cyc(); reload = 1'b0;
    wait_cfg_rdy();
    cfg(4'd1, 1'b0);
    cfg(4'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_count", 32'(s_count), 32'd0);
    chk("t6_rst_out_vld", 32'(out_vld), 32'd0);
    chk("t6_rst_total", 32'(total_count), 32'd0);
    chk("t6_rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cfg(4'd1, 1'b0);
    cfg(4'd1, 1'b1);
    chk("t6_total", 32'(total_count), 32'd2);
    send(4'd1, 4'd1, 8'd1, 1'b1);
    cyc();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
